// File: rtl/rv32i_types.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rv32i_types : shared fetch-stage types and constants.          rev 1.0   |
// +--------------------------------------------------------------------------+
package rv32i_types;

  typedef enum logic [1:0] {
    S_REQ     = 2'd0,
    S_HOLD    = 2'd1,
    S_DISCARD = 2'd2
  } if_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage
`default_nettype wire

// File: rtl/pc_register.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pc_register : 32-bit load register, sync reset to RESET_PC.    rev 1.0   |
// +--------------------------------------------------------------------------+
module pc_register #(
  parameter logic [31:0] RESET_PC = 32'h0000_0060
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic [31:0] pc_i,
  output logic [31:0] pc_o
);

  logic [31:0] pc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else if (load_i) begin
      pc_q <= pc_i;
    end
  end

  assign pc_o = pc_q;

endmodule
`default_nettype wire

// File: rtl/if_fetch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | if_fetch_unit : instruction fetch with skid buffer and redirect. rev 1.0 |
// +--------------------------------------------------------------------------+
module if_fetch_unit
  import rv32i_types::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0060
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ID_pc_mux_sel,
  input  logic [31:0] ID_jmp_pc,
  input  logic        flush,
  input  logic        stall,
  output logic        inst_read,
  output logic [31:0] inst_addr,
  input  logic        inst_resp,
  input  logic [31:0] inst_rdata,
  output logic [31:0] IF_ID_pc,
  output logic [31:0] IF_ID_instr,
  output logic        IF_ID_valid
);

  if_state_t   state_q, state_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [31:0] skid_addr_q, skid_addr_d;
  logic [31:0] ifid_pc_q, ifid_pc_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic        pc_ld;
  logic [31:0] pc_d, pc_q;
  logic [31:0] w_target;
  logic [31:0] w_seq_addr;

  pc_register #(.RESET_PC(RESET_PC)) u_pc (
    .clk    (clk),
    .rst    (rst),
    .load_i (pc_ld),
    .pc_i   (pc_d),
    .pc_o   (pc_q)
  );

  assign w_target   = align_word(ID_jmp_pc);
  assign w_seq_addr = req_addr_q + 32'd4;

  always_comb begin
    state_d      = state_q;
    req_addr_d   = req_addr_q;
    skid_instr_d = skid_instr_q;
    skid_addr_d  = skid_addr_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_instr_d = ifid_instr_q;
    ifid_valid_d = ifid_valid_q;
    pc_ld        = 1'b0;
    pc_d         = pc_q;

    // A redirect wins over stall in every state and kills any buffered word.
    if (ID_pc_mux_sel) begin
      pc_ld        = 1'b1;
      pc_d         = w_target;
      ifid_valid_d = 1'b0;
      skid_instr_d = NOP_INSTR;
      skid_addr_d  = 32'h0;
    end

    unique case (state_q)
      S_REQ: begin
        if (ID_pc_mux_sel) begin
          if (inst_resp) req_addr_d = w_target;
          else           state_d    = S_DISCARD;
        end else if (inst_resp) begin
          pc_ld = 1'b1;
          pc_d  = w_seq_addr;
          if (stall) begin
            skid_instr_d = inst_rdata;
            skid_addr_d  = req_addr_q;
            state_d      = S_HOLD;
          end else begin
            ifid_instr_d = inst_rdata;
            ifid_pc_d    = req_addr_q;
            ifid_valid_d = 1'b1;
            req_addr_d   = w_seq_addr;
          end
        end else if (!stall) begin
          ifid_valid_d = 1'b0;
        end
      end
      S_HOLD: begin
        if (ID_pc_mux_sel) begin
          req_addr_d = w_target;
          state_d    = S_REQ;
        end else if (!stall) begin
          ifid_instr_d = skid_instr_q;
          ifid_pc_d    = skid_addr_q;
          ifid_valid_d = 1'b1;
          req_addr_d   = skid_addr_q + 32'd4;
          state_d      = S_REQ;
        end
      end
      S_DISCARD: begin
        // Stale response arrives: restart from the latest redirect target.
        if (inst_resp) begin
          req_addr_d = ID_pc_mux_sel ? w_target : pc_q;
          state_d    = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase

    if (flush) ifid_valid_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_REQ;
      req_addr_q   <= RESET_PC;
      skid_instr_q <= NOP_INSTR;
      skid_addr_q  <= 32'h0;
      ifid_pc_q    <= 32'h0;
      ifid_instr_q <= NOP_INSTR;
      ifid_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_addr_q   <= req_addr_d;
      skid_instr_q <= skid_instr_d;
      skid_addr_q  <= skid_addr_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_valid_q <= ifid_valid_d;
    end
  end

  assign inst_read   = (state_q != S_HOLD) && !rst;
  assign inst_addr   = req_addr_q;
  assign IF_ID_pc    = ifid_pc_q;
  assign IF_ID_instr = ifid_instr_q;
  assign IF_ID_valid = ifid_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_if_fetch_unit : scoreboard bench for if_fetch_unit.         rev 1.0   |
// +--------------------------------------------------------------------------+
module tb_if_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        ID_pc_mux_sel;
  logic [31:0] ID_jmp_pc;
  logic        flush;
  logic        stall;
  logic        inst_read;
  logic [31:0] inst_addr;
  logic        inst_resp;
  logic [31:0] inst_rdata;
  logic [31:0] IF_ID_pc;
  logic [31:0] IF_ID_instr;
  logic        IF_ID_valid;

  logic        zero_wait;
  logic        man_resp;
  int          checks = 0;
  int          errors = 0;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  if_fetch_unit #(.RESET_PC(32'h0000_0060)) dut (
    .clk           (clk),
    .rst           (rst),
    .ID_pc_mux_sel (ID_pc_mux_sel),
    .ID_jmp_pc     (ID_jmp_pc),
    .flush         (flush),
    .stall         (stall),
    .inst_read     (inst_read),
    .inst_addr     (inst_addr),
    .inst_resp     (inst_resp),
    .inst_rdata    (inst_rdata),
    .IF_ID_pc      (IF_ID_pc),
    .IF_ID_instr   (IF_ID_instr),
    .IF_ID_valid   (IF_ID_valid)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h60) return 32'h0010_0093;
    if (a == 32'h64) return 32'h0020_0113;
    return a ^ 32'h5A5A_0013;
  endfunction

  // Memory model: zero-wait answers any request at once; otherwise manual.
  assign inst_resp  = zero_wait ? inst_read : man_resp;
  assign inst_rdata = mem_word(inst_addr);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [31:0] a);
    exp_q.push_back({a, mem_word(a)});
  endtask

  // Any edge taken without stall or reset that leaves valid=1 presents a new word.
  always @(posedge clk) begin
    logic s_stall, s_rst;
    logic [63:0] e;
    s_stall = stall;
    s_rst   = rst;
    #2;
    if (!s_rst && !s_stall && IF_ID_valid) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_valid", {31'b0, IF_ID_valid}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("sb_pc", IF_ID_pc, e[63:32]);
        chk("sb_instr", IF_ID_instr, e[31:0]);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst = 1'b1; ID_pc_mux_sel = 1'b0; ID_jmp_pc = 32'h0;
    flush = 1'b0; stall = 1'b0; zero_wait = 1'b0; man_resp = 1'b0;
    repeat (3) tick();
    chk("rst_read", {31'b0, inst_read}, 32'd0);
    chk("rst_valid", {31'b0, IF_ID_valid}, 32'd0);
    chk("rst_instr", IF_ID_instr, NOP);
    chk("rst_pc", IF_ID_pc, 32'h0);
    chk("rst_addr", inst_addr, 32'h60);

    // Zero-wait stream after release.
    zero_wait = 1'b1;
    push_exp(32'h60);
    push_exp(32'h64);
    rst = 1'b0;
    #1;
    chk("first_read", {31'b0, inst_read}, 32'd1);
    chk("first_addr", inst_addr, 32'h60);
    tick();
    chk("second_addr", inst_addr, 32'h64);
    tick();
    chk("third_addr", inst_addr, 32'h68);

    // Stall three cycles while 0x68 returns.
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_pc", IF_ID_pc, 32'h64);
      chk("hold_valid", {31'b0, IF_ID_valid}, 32'd1);
      chk("hold_read", {31'b0, inst_read}, 32'd0);
    end
    stall = 1'b0;
    zero_wait = 1'b0;
    push_exp(32'h68);
    tick();
    chk("post_hold_addr", inst_addr, 32'h6C);
    chk("post_hold_read", {31'b0, inst_read}, 32'd1);

    // Redirect to 0x203 with the 0x6C read still outstanding.
    ID_pc_mux_sel = 1'b1; ID_jmp_pc = 32'h203;
    tick();
    ID_pc_mux_sel = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("discard_addr", inst_addr, 32'h6C);
      chk("discard_read", {31'b0, inst_read}, 32'd1);
      chk("discard_valid", {31'b0, IF_ID_valid}, 32'd0);
      tick();
    end
    man_resp = 1'b1;
    tick();
    man_resp = 1'b0;
    chk("stale_valid", {31'b0, IF_ID_valid}, 32'd0);
    chk("redir_addr", inst_addr, 32'h200);

    // Accept 0x200, then redirect+stall+flush together.
    zero_wait = 1'b1;
    push_exp(32'h200);
    tick();
    stall = 1'b1; flush = 1'b1; ID_pc_mux_sel = 1'b1; ID_jmp_pc = 32'h400;
    tick();
    stall = 1'b0; flush = 1'b0;
    chk("rsf_valid", {31'b0, IF_ID_valid}, 32'd0);
    chk("rsf_addr", inst_addr, 32'h400);

    // Redirect to 0x80, leave it pending, then reset.
    ID_jmp_pc = 32'h80;
    tick();
    ID_pc_mux_sel = 1'b0;
    zero_wait = 1'b0;
    chk("pend80_addr", inst_addr, 32'h80);
    tick();
    rst = 1'b1;
    #1;
    chk("midrst_read", {31'b0, inst_read}, 32'd0);
    tick();
    chk("midrst_instr", IF_ID_instr, NOP);
    chk("midrst_valid", {31'b0, IF_ID_valid}, 32'd0);
    rst = 1'b0;
    #1;
    chk("rel_addr", inst_addr, 32'h60);
    chk("rel_read", {31'b0, inst_read}, 32'd1);

    // Wrap at the top of the address space; misaligned target gets aligned.
    zero_wait = 1'b1; ID_pc_mux_sel = 1'b1; ID_jmp_pc = 32'hFFFF_FFFF;
    tick();
    ID_pc_mux_sel = 1'b0;
    chk("top_addr", inst_addr, 32'hFFFF_FFFC);
    push_exp(32'hFFFF_FFFC);
    tick();
    chk("wrap_addr", inst_addr, 32'h0);
    push_exp(32'h0);
    tick();

    // Flush kills an accepted response; then a plain bubble.
    flush = 1'b1;
    tick();
    flush = 1'b0;
    zero_wait = 1'b0;
    chk("flush_valid", {31'b0, IF_ID_valid}, 32'd0);
    chk("flush_addr", inst_addr, 32'h8);
    tick();
    chk("bubble_valid", {31'b0, IF_ID_valid}, 32'd0);

    #5;
    chk("sb_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
